// File: rtl/cmplt_arbiter.sv
// Completion arbiter: picks up to two of four completion
// requesters per cycle, round-robin, into a registered 2-slot output.
module cmplt_arbiter #(
  parameter int PR_ADDR_W = 6,
  parameter int ROB_W     = 5,
  parameter int ARCH_W    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [4*(ROB_W+ARCH_W+PR_ADDR_W)-1:0]  req_data,
  input  logic [3:0]                             req_valid,
  output logic [3:0]                             req_ready,
  input  logic                                   flush,
  output logic [2*(ROB_W+ARCH_W+PR_ADDR_W)-1:0]  out_data,
  output logic [1:0]                             out_valid,
  input  logic                                   out_ready
);

  localparam int E = ROB_W + ARCH_W + PR_ADDR_W;

  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   out_valid_q, out_valid_d;
  logic [E-1:0] slot0_q, slot0_d;
  logic [E-1:0] slot1_q, slot1_d;

  logic         adv;
  logic         take;
  logic         g0_vld, g1_vld;
  logic [1:0]   g0_idx, g1_idx;
  logic [1:0]   scan_idx;

  assign adv  = ~(out_valid_q[0] | out_valid_q[1]) | out_ready;
  assign take = adv & ~flush & rst;

  // First and second valid requester in rotating scan order
  always_comb begin
    g0_vld   = 1'b0;
    g1_vld   = 1'b0;
    g0_idx   = 2'd0;
    g1_idx   = 2'd0;
    scan_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + k[1:0];
      if (req_valid[scan_idx]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = scan_idx;
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = 4'b0000;
    if (take) begin
      if (g0_vld) req_ready[g0_idx] = 1'b1;
      if (g1_vld) req_ready[g1_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    unique case (1'b1)
      flush: begin
        out_valid_d = 2'b00;
      end
      (!flush && adv): begin
        out_valid_d = {g1_vld, g0_vld};
        slot0_d     = req_data[g0_idx*E +: E];
        slot1_d     = req_data[g1_idx*E +: E];
        if (g0_vld)
          ptr_d = (g1_vld ? g1_idx : g0_idx) + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= 2'd0;
      out_valid_q <= 2'b00;
      slot0_q     <= '0;
      slot1_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = {slot1_q, slot0_q};

endmodule

// File: doc/cmplt_arbiter.md
CMPLT_ARBITER -- requirements
Module: cmplt_arbiter

Interface
REQ-001 SHALL have parameter PR_ADDR_W, default 6, physical register tag width.
REQ-002 SHALL have parameter ROB_W, default 5, ROB entry number width.
REQ-003 SHALL have parameter ARCH_W, default 4, architectural register width; E = ROB_W+ARCH_W+PR_ADDR_W is the completion record width, packed {rob, arch, phys}, with phys in the LSBs.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port req_data, input, 4*E, completion records from 4 requesters; index 0=alu0, 1=alu1, 2=mem, 3=term.
REQ-007 SHALL have port req_valid, input, 4, per-requester record valid.
REQ-008 SHALL have port req_ready, output, 4, per-requester accept; combinational.
REQ-009 SHALL have port flush, input, 1, drop held and incoming completions (terminator mispredict).
REQ-010 SHALL have port out_data, output, 2*E, slot0 in the LSBs, slot1 in the MSBs; registered.
REQ-011 SHALL have port out_valid, output, 2, per-slot valid; registered.
REQ-012 SHALL have port out_ready, input, 1, downstream (ROB/frontend) accepts both slots this cycle.

Function
REQ-013 SHALL grant at most 2 requesters per cycle; a transfer on requester i occurs when req_valid[i] & req_ready[i].
REQ-014 SHALL define adv = ~(out_valid[0] | out_valid[1]) | out_ready; req_ready[i] SHALL be 0 for all i when adv=0 or flush=1.
REQ-015 SHALL use a 2-bit rotating pointer ptr; the scan order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-016 SHALL grant the first valid requester in scan order to slot0 and the second to slot1; requesters with valid=0 are skipped.
REQ-017 SHALL assert req_ready[i] only for granted requesters; req_ready SHALL never depend on req_ready of other requesters.
REQ-018 SHALL, on an adv=1, flush=0 cycle, load out_data/out_valid with the granted records; a slot with no grant SHALL load valid=0, and a lone grant SHALL occupy slot0.
REQ-019 SHALL update ptr <= (index of the last granted requester + 1) mod 4 when at least one grant occurs; otherwise ptr holds.
REQ-020 SHALL hold out_data/out_valid and ptr unchanged while adv=0 (stall); no record is lost or duplicated.
REQ-021 SHALL give one-cycle latency: a record accepted in cycle n appears on out_* in cycle n+1.
REQ-022 SHALL, on flush=1, clear out_valid to 2'b00 on the next edge regardless of out_ready; ptr holds; no requester is accepted that cycle.
REQ-023 SHALL keep out_valid[1]=1 implying out_valid[0]=1 at all times.
REQ-024 SHALL guarantee starvation freedom: a continuously valid requester is granted within 2 adv=1 cycles.
REQ-025 SHALL not require req_data to be stable when req_valid=0; out_data is don't-care where out_valid=0.

Reset
REQ-026 SHALL, while rst=0, asynchronously force out_valid=2'b00, out_data=0 and ptr=0.
REQ-027 SHALL drive req_ready=4'b0000 while rst=0.
REQ-028 SHALL begin arbitration on the first rising edge after rst deasserts, with ptr=0.
REQ-029 SHALL discard any in-flight output record if rst asserts mid-operation; no pending state survives.

Verification
REQ-030 Directed scenario: ptr=0, req_valid=4'b1111, out_ready=1 -> req_ready=4'b0011; next cycle out_data carries alu0 in slot0 and alu1 in slot1, out_valid=2'b11, ptr=2.
REQ-031 Directed scenario: sustained req_valid=4'b1111, out_ready=1 for 4 cycles -> grant pairs {0,1},{2,3},{0,1},{2,3}.
REQ-032 Directed scenario: out_valid=2'b11, out_ready=0, req_valid=4'b0100 -> req_ready=0 and outputs held; when out_ready=1, mem is accepted to slot0 and out_valid=2'b01 the next cycle.
REQ-033 Directed scenario: ptr=3, req_valid=4'b1001 -> slot0=term, slot1=alu0, ptr=1.
REQ-034 Directed scenario: flush=1 with out_valid=2'b11, out_ready=0, req_valid=4'b1111 -> req_ready=0, next cycle out_valid=2'b00, ptr unchanged.
REQ-035 Directed scenario: drive rst=0 asynchronously mid-stall with out_valid=2'b11 -> out_valid=2'b00 immediately without a clock edge; after release, req_valid=4'b0010 is granted to slot0.
